// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the register file with
// write-pending scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R_ZERO = '0;

  // Mode 1 seeds register i with i so a fresh machine reads distinguishable values.
  function automatic int unsigned resetValue(input int unsigned idx, input int mode);
    return (mode == 1 && idx != 0) ? idx : 0;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback,
// destination reservation and scoreboard status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic [NREGS-1:0]         busy_vec;
  logic                     pend_err;
  logic [DATA_W-1:0]        probe;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ready, busy_vec, pend_err, probe
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, iss_ready, busy_vec, pend_err, probe
  );

endinterface

// File: rtl/pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// Simultaneous inc and dec cancel; inc at max and dec at zero are ignored.
module pend_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         nonzero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !at_max) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && nonzero) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_max  = &count_q;
  assign nonzero = |count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with zero register, write-to-read bypass,
// probe port and a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_RD     = 2,
  parameter int PEND_W     = 2,
  parameter int PROBE_IDX  = 1,
  parameter int RESET_MODE = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R_ZERO);

  logic [DATA_W-1:0]            regs_q [NREGS];
  logic [NREGS-1:0][PEND_W-1:0] pendCount;
  logic [NREGS-1:0]             atMax;
  logic [NREGS-1:0]             nonZero;
  logic [NREGS-1:0]             wbVec;
  logic [NREGS-1:0]             issFire;
  logic                         wrLive;
  logic                         pendErr_q;
  logic                         pendErr_d;

  assign wrLive = bus.wr_en && (bus.wr_addr != ZERO_ADDR);

  // A writeback in the same cycle frees a slot, so a full register can still accept an issue.
  assign bus.iss_ready = (bus.iss_addr == ZERO_ADDR) || !atMax[bus.iss_addr] ||
                         (bus.wr_en && (bus.wr_addr == bus.iss_addr));

  always_comb begin
    wbVec   = '0;
    issFire = '0;
    for (int r = 1; r < NREGS; r++) begin
      wbVec[r]   = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && nonZero[r];
      issFire[r] = bus.iss_en && bus.iss_ready && (bus.iss_addr == ADDR_W'(r));
    end
  end

  assign pendCount[0] = '0;
  assign atMax[0]     = 1'b0;
  assign nonZero[0]   = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : gPend
    pend_counter #(
      .W (PEND_W)
    ) uCnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (issFire[r]),
      .dec     (wbVec[r]),
      .count   (pendCount[r]),
      .at_max  (atMax[r]),
      .nonzero (nonZero[r])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(resetValue(i, RESET_MODE));
      end
    end else if (wrLive) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // An unexpected writeback is still written; the error only flags the bookkeeping slip.
  assign pendErr_d = pendErr_q | (wrLive && !nonZero[bus.wr_addr]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendErr_q <= 1'b0;
    end else begin
      pendErr_q <= pendErr_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    addr        = '0;
    word        = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
      word = regs_q[addr];
      if (addr == ZERO_ADDR) begin
        word = '0;
      end else if (bus.wr_en && (bus.wr_addr == addr)) begin
        word = bus.wr_data;
      end
      bus.rd_data[p*DATA_W +: DATA_W] = word;
      bus.rd_busy[p] = (pendCount[addr] - PEND_W'(wbVec[addr])) != '0;
    end
  end

  assign bus.busy_vec = nonZero;
  assign bus.pend_err = pendErr_q;
  assign bus.probe    = regs_q[PROBE_IDX];

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file with an integrated write-pending scoreboard for the pipelined MIPS datapath.
- Adds write-enable gating, a hard-wired zero register, write-to-read bypass and a probe port at a selectable index.
- Tracks in-flight writes per register with saturating up/down counters, so issue/hazard logic can stall on busy sources.
- Sits between decode (issue, reads) and writeback (writes).

Parameters:
- DATA_W, 32: register width.
- ADDR_W, 5: address width; NREGS = 2**ADDR_W.
- NUM_RD, 2: number of combinational read ports.
- PEND_W, 2: pending-counter width; PMAX = 2**PEND_W-1 in-flight writes per register.
- PROBE_IDX, 1: register driven onto probe.
- RESET_MODE, 1: 0 = all registers reset to 0; 1 = register i resets to i (register 0 always 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses slice p.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  source register still has a pending write after this cycle's writeback.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  reserve a destination register.
- iss_addr  in  ADDR_W  destination being reserved.
- iss_ready  out  1  reservation accepted this cycle.
- busy_vec  out  NREGS  bit r = pending count of r is nonzero (registered).
- pend_err  out  1  sticky: writeback arrived with zero pending count.
- probe  out  DATA_W  stored contents of PROBE_IDX (no bypass).

Behaviour:
- Reset (async assert, sync-safe release):
  - Registers load per RESET_MODE; all counters 0; busy_vec 0; pend_err 0.
  - Resulting outputs: iss_ready 1; rd_busy 0; rd_data and probe show reset contents.
- Reset mid-operation discards all pending state immediately, with no clock edge needed.
- Register 0:
  - Reads 0 and is never busy.
  - Writes to it are ignored.
  - Issues to it are always accepted and never counted.
  - Writebacks to it never raise pend_err.
- Reads (combinational, zero latency):
  - If wr_en and wr_addr == rd_addr[p] != 0, rd_data[p] = wr_data (bypass).
  - Otherwise rd_data[p] = stored value.
- Write: on clk, if wr_en and wr_addr != 0, the register takes wr_data.
- Counters, per register r != 0:
  - wb = wr_en && wr_addr == r && pend[r] != 0.
  - iss_fire = iss_en && iss_ready && iss_addr == r.
  - pend[r] <= pend[r] + iss_fire - wb.
- iss_ready = iss_addr == 0 || pend[iss_addr] != PMAX || (wr_en && wr_addr == iss_addr). A simultaneous writeback frees the slot, so the count stays PMAX.
- rd_busy[p] = (pend[a] - wb_to_a) != 0, where a = rd_addr[p]. A same-cycle issue is not visible until the next cycle.
- pend_err: wr_en with wr_addr != 0 and pend == 0.
  - Data is still written.
  - The counter stays 0, or becomes 1 if the same cycle also issues to that register.
  - pend_err is set the next cycle and held until reset.
- Simultaneous issue and writeback to the same register with pend in 1..PMAX-1: the count is unchanged.
- No wrap-around: the counter never exceeds PMAX (guarded by iss_ready) and never goes below 0 (guarded by wb).

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W;
  - typedefs word_t and reg_addr_t;
  - constant R_ZERO = 0.
- One sub-module, pend_counter: a saturating up/down counter with inc, dec, count, at_max and nonzero outputs. It is generated once per register, for registers 1..NREGS-1.

Test Plan:
- Reset: RESET_MODE=1, release rst, rd_addr = {5, 0} -> rd_data = {5, 0}, probe = 1, busy_vec = 0, iss_ready = 1.
- Bypass: wr_en, wr_addr = 3, wr_data = 0xDEADBEEF, rd_addr port0 = 3 in the same cycle -> rd_data0 = 0xDEADBEEF that cycle and stored afterwards. The same write to register 0 -> register 0 still reads 0.
- Pending counts: issue register 7 twice, so busy_vec[7] = 1 (PEND_W=2). Writeback 7 once -> still busy. In the second writeback cycle rd_busy for 7 = 0, and busy_vec[7] = 0 the next cycle.
- Saturation: issue register 9 three times (count 3), then:
  - a 4th issue alone -> iss_ready = 0, count stays 3;
  - a 4th issue with wr_en to 9 -> iss_ready = 1, count stays 3.
- Error: wr_en to register 4 with no prior issue, data 0x55 -> register 4 = 0x55, pend_err = 1 next cycle and stays 1 for 10 cycles of idle.
- Reset mid-operation: with pend[7] = 2, pulse rst low between edges -> busy_vec = 0 and registers reinitialised immediately; a subsequent writeback to 7 raises pend_err.
